// File: rtl/pipe_pkg.sv
// Shared decode helpers for the IF/ID/EX hazard controller: opcodes,
// instruction field positions, controller states and register-usage functions.
package pipe_pkg;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RS_MSB = 11;
  localparam int RS_LSB = 10;
  localparam int RT_MSB = 9;
  localparam int RT_LSB = 8;
  localparam int RD_MSB = 7;
  localparam int RD_LSB = 6;

  typedef logic [3:0] opcode_t;
  typedef logic [1:0] reg_t;

  localparam opcode_t OPC_R0   = 4'b0000;
  localparam opcode_t OPC_R1   = 4'b0001;
  localparam opcode_t OPC_R2   = 4'b0010;
  localparam opcode_t OPC_R3   = 4'b0011;
  localparam opcode_t OPC_ADDI = 4'b0100;
  localparam opcode_t OPC_LW   = 4'b0101;
  localparam opcode_t OPC_SW   = 4'b0110;
  localparam opcode_t OPC_R7   = 4'b0111;
  localparam opcode_t OPC_BEQ  = 4'b1000;
  localparam opcode_t OPC_BNE  = 4'b1001;
  localparam opcode_t OPC_HALT = 4'b1111;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } state_e;

  function automatic logic is_rtype(opcode_t op);
    return (op == OPC_R0) || (op == OPC_R1) || (op == OPC_R2) ||
           (op == OPC_R3) || (op == OPC_R7);
  endfunction

  function automatic logic writes_reg(opcode_t op);
    return is_rtype(op) || (op == OPC_ADDI) || (op == OPC_LW);
  endfunction

  // Only meaningful when writes_reg() is true for the same instruction.
  function automatic reg_t dest_reg(logic [15:0] ir);
    if (is_rtype(ir[OP_MSB:OP_LSB])) return ir[RD_MSB:RD_LSB];
    return ir[RT_MSB:RT_LSB];
  endfunction

  function automatic logic uses_rt(opcode_t op);
    return is_rtype(op) || (op == OPC_SW) || (op == OPC_BEQ) || (op == OPC_BNE);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter on the pipeline (falling) edge with synchronous
// active-low clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: step only while below the all-ones ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Count register, cleared synchronously.
  always_ff @(negedge clock) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Sequencing controller for the 3-stage IF/ID/EX pipeline: RAW stalls,
// taken-branch flush, data-memory wait, HALT, and stall/flush counters.
// Build option: define FORWARD_EN to replace RAW stalls with EX->ID forwarding.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   RUN      | normal issue; hazards resolved cycle by cycle
//   MEM_WAIT | LW/SW in EX waiting for dmem_ready, pipeline frozen
//   HALTED   | HALT retired from EX; frozen until reset
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int          CNT_W   = 16,
  parameter logic [3:0]  OP_HALT = OPC_HALT
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [15:0]      ifid_ir,
  input  logic [15:0]      idex_ir,
  input  logic             idex_valid,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             pc_sel_branch,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             idex_hold,
  output logic             dmem_req,
  output logic             fwd_a,
  output logic             fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_e  state_q, state_d, eff_state;
  opcode_t id_op, ex_op;
  reg_t    id_rs, id_rt, ex_dest;
  logic    ex_writes, raw_a, raw_b, raw_stall, fwd_en;
  logic    ex_mem, mem_stall, ex_halt;
  logic    stall_inc, flush_inc;

`ifdef FORWARD_EN
  assign fwd_en = 1'b1;
`else
  assign fwd_en = 1'b0;
`endif

  assign id_op   = ifid_ir[OP_MSB:OP_LSB];
  assign id_rs   = ifid_ir[RS_MSB:RS_LSB];
  assign id_rt   = ifid_ir[RT_MSB:RT_LSB];
  assign ex_op   = idex_ir[OP_MSB:OP_LSB];
  assign ex_dest = dest_reg(idex_ir);

  // $0 is hardwired, so a write to it never creates a dependency.
  assign ex_writes = idex_valid && writes_reg(ex_op) && (ex_dest != 2'd0);
  assign raw_a     = ex_writes && (id_op != OP_HALT) && (id_rs == ex_dest);
  assign raw_b     = ex_writes && uses_rt(id_op) && (id_rt == ex_dest);
  assign raw_stall = !fwd_en && (raw_a || raw_b);

  assign ex_mem    = idex_valid && ((ex_op == OPC_LW) || (ex_op == OPC_SW));
  assign mem_stall = ex_mem && !dmem_ready;
  assign ex_halt   = idex_valid && (ex_op == OP_HALT);

  // While reset is asserted the outputs decode as if already back in RUN.
  assign eff_state = resetn ? state_q : RUN;

  // State register on the pipeline edge.
  always_ff @(negedge clock) begin
    if (!resetn) state_q <= RUN;
    else         state_q <= state_d;
  end

  // Next state: HALTED is sticky; otherwise track the EX memory handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HALTED:  state_d = HALTED;
      default: begin
        if (ex_halt)        state_d = HALTED;
        else if (mem_stall) state_d = MEM_WAIT;
        else                state_d = RUN;
      end
    endcase
  end

  // Pipeline controls by priority: halted, memory wait, branch, RAW, fetch wait.
  always_comb begin
    pc_write      = 1'b0;
    pc_sel_branch = 1'b0;
    ifid_write    = 1'b0;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    idex_hold     = 1'b0;
    dmem_req      = 1'b0;
    fwd_a         = 1'b0;
    fwd_b         = 1'b0;
    flush_inc     = 1'b0;
    if (eff_state == HALTED) begin
      idex_bubble = 1'b1;
    end else begin
      dmem_req = ex_mem;
      if (mem_stall) begin
        idex_hold = 1'b1;
      end else if (branch_taken) begin
        // ID holds a wrong-path instruction, so any RAW match is irrelevant.
        pc_write      = 1'b1;
        pc_sel_branch = 1'b1;
        ifid_flush    = 1'b1;
        idex_bubble   = 1'b1;
        flush_inc     = 1'b1;
      end else if (raw_stall) begin
        idex_bubble = 1'b1;
      end else begin
        fwd_a = fwd_en && raw_a;
        fwd_b = fwd_en && raw_b;
        if (!imem_ready) begin
          ifid_flush = 1'b1;
        end else begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
        end
      end
    end
  end

  assign halted    = (eff_state == HALTED);
  assign stall_inc = !halted && !pc_write;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock  (clock),
    .resetn (resetn),
    .inc    (stall_inc),
    .count  (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clock  (clock),
    .resetn (resetn),
    .inc    (flush_inc),
    .count  (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random traffic, every
// cycle compared against an instruction-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int CW  = 4;
  localparam int SAT = 15;

  localparam logic [15:0] I_ADDI = 16'h410F; // addi $1,$0,15
  localparam logic [15:0] I_AND  = 16'h26C0; // and  $3,$1,$2
  localparam logic [15:0] I_IND  = 16'h0BC0; // R-type reading $2,$3
  localparam logic [15:0] I_LW   = 16'h5100; // lw   $1,0($0)
  localparam logic [15:0] I_BEQ  = 16'h8100; // beq  $0,$1
  localparam logic [15:0] I_HALT = 16'hF000;

  logic          clock = 1'b0;
  logic          resetn;
  logic [15:0]   ifid_ir, idex_ir;
  logic          idex_valid, branch_taken, imem_ready, dmem_ready;
  logic          pc_write, pc_sel_branch, ifid_write, ifid_flush;
  logic          idex_bubble, idex_hold, dmem_req, fwd_a, fwd_b, halted;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  bit m_halted = 1'b0;
  bit m_known  = 1'b0;
  int m_stall  = 0;
  int m_flush  = 0;

  pipe_hazard_ctrl #(.CNT_W(CW), .OP_HALT(4'b1111)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .ifid_ir       (ifid_ir),
    .idex_ir       (idex_ir),
    .idex_valid    (idex_valid),
    .branch_taken  (branch_taken),
    .imem_ready    (imem_ready),
    .dmem_ready    (dmem_ready),
    .pc_write      (pc_write),
    .pc_sel_branch (pc_sel_branch),
    .ifid_write    (ifid_write),
    .ifid_flush    (ifid_flush),
    .idex_bubble   (idex_bubble),
    .idex_hold     (idex_hold),
    .dmem_req      (dmem_req),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .halted        (halted),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Register an instruction writes, or -1 when it writes none.
  function automatic int dest_of(logic [15:0] ir);
    case (int'(ir[15:12]))
      0, 1, 2, 3, 7: return int'(ir[7:6]);
      4, 5:          return int'(ir[9:8]);
      default:       return -1;
    endcase
  endfunction

  function automatic bit reads_rs(logic [15:0] ir);
    return ir[15:12] != 4'hF;
  endfunction

  function automatic bit reads_rt(logic [15:0] ir);
    return int'(ir[15:12]) inside {0, 1, 2, 3, 6, 7, 8, 9};
  endfunction

  function automatic logic [15:0] rand_ir();
    int op;
    op = $urandom_range(0, 15);
    if (op == 15 && $urandom_range(0, 7) != 0) op = $urandom_range(0, 14);
    return {4'(op), 12'($urandom)};
  endfunction

  task automatic drv(input logic [15:0] a, input logic [15:0] b, input logic v,
                     input logic br, input logic im, input logic dm, input logic rst);
    ifid_ir = a; idex_ir = b; idex_valid = v; branch_taken = br;
    imem_ready = im; dmem_ready = dm; resetn = rst;
  endtask

  // One pipeline cycle: compare outputs at posedge, advance the model at negedge.
  task automatic step();
    bit e_pc, e_sel, e_iw, e_ifl, e_bub, e_hold, e_dreq, e_fa, e_fb, e_halt;
    bit memop, haz_a, haz_b, stall_ev, flush_ev;
    int d;
    {e_pc, e_sel, e_iw, e_ifl, e_bub, e_hold, e_dreq, e_fa, e_fb} = '0;
    stall_ev = 1'b0; flush_ev = 1'b0;
    @(posedge clock);
    e_halt = resetn ? m_halted : 1'b0;
    if (e_halt) begin
      e_bub = 1'b1;
    end else begin
      memop  = idex_valid && (idex_ir[15:12] == 4'd5 || idex_ir[15:12] == 4'd6);
      e_dreq = memop;
      if (memop && !dmem_ready) begin
        e_hold = 1'b1; stall_ev = 1'b1;
      end else if (branch_taken) begin
        e_pc = 1'b1; e_sel = 1'b1; e_ifl = 1'b1; e_bub = 1'b1; flush_ev = 1'b1;
      end else begin
        d = idex_valid ? dest_of(idex_ir) : -1;
        haz_a = d > 0 && reads_rs(ifid_ir) && int'(ifid_ir[11:10]) == d;
        haz_b = d > 0 && reads_rt(ifid_ir) && int'(ifid_ir[9:8]) == d;
`ifdef FORWARD_EN
        e_fa = haz_a; e_fb = haz_b;
`else
        if (haz_a || haz_b) begin
          e_bub = 1'b1; stall_ev = 1'b1;
        end else
`endif
        if (!imem_ready) begin
          e_ifl = 1'b1; stall_ev = 1'b1;
        end else begin
          e_pc = 1'b1; e_iw = 1'b1;
        end
      end
    end
    chk("pc_write", pc_write, e_pc);
    chk("pc_sel_branch", pc_sel_branch, e_sel);
    chk("ifid_write", ifid_write, e_iw);
    chk("ifid_flush", ifid_flush, e_ifl);
    chk("idex_bubble", idex_bubble, e_bub);
    chk("idex_hold", idex_hold, e_hold);
    chk("dmem_req", dmem_req, e_dreq);
    chk("fwd_a", fwd_a, e_fa);
    chk("fwd_b", fwd_b, e_fb);
    chk("halted", halted, e_halt);
    if (m_known) begin
      chk("stall_cnt", stall_cnt, m_stall);
      chk("flush_cnt", flush_cnt, m_flush);
    end
    if (!resetn) begin
      m_halted = 1'b0; m_stall = 0; m_flush = 0; m_known = 1'b1;
    end else begin
      if (stall_ev && m_stall < SAT) m_stall++;
      if (flush_ev && m_flush < SAT) m_flush++;
      if (!m_halted && idex_valid && idex_ir[15:12] == 4'hF) m_halted = 1'b1;
    end
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    drv(16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
  endtask

  initial begin
    drv(16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();

    // Back-to-back addi -> and dependency on $1.
    drv(I_AND, I_ADDI, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1); step();
    drv(I_AND, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);  step();
`ifdef FORWARD_EN
    chk("hazard_stall_cnt", stall_cnt, 0);
`else
    chk("hazard_stall_cnt", stall_cnt, 1);
`endif

    // Taken branch, then a taken branch over a live RAW match.
    do_reset();
    drv(I_AND, I_BEQ, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);  step();
    drv(I_AND, I_ADDI, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1); step();
    drv(I_IND, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);  step();
    chk("branch_flush_cnt", flush_cnt, 2);
    chk("branch_stall_cnt", stall_cnt, 0);

    // LW waits three cycles for data memory.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drv(I_IND, I_LW, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1); step();
    end
    drv(I_IND, I_LW, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1); step();
    chk("memwait_stall_cnt", stall_cnt, 3);

    // Reset in the middle of a memory wait.
    drv(I_IND, I_LW, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1); step();
    drv(I_IND, I_LW, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); step();
    drv(I_IND, I_LW, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1); step();

    // Fetch wait for two cycles.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drv(I_IND, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); step();
    end
    drv(I_IND, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1); step();
    chk("fetch_stall_cnt", stall_cnt, 2);

    // Counter saturation.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drv(I_IND, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); step();
    end
    chk("stall_cnt_saturated", stall_cnt, SAT);

    // HALT freezes the pipeline until reset.
    do_reset();
    drv(I_IND, I_HALT, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1); step();
    for (int i = 0; i < 10; i++) begin
      drv(rand_ir(), rand_ir(), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); step();
    end
    chk("halt_persist", halted, 1);
    do_reset();
    drv(I_IND, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    chk("halt_cleared", halted, 0);
    chk("reset_stall_cnt", stall_cnt, 0);
    step();

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      drv(rand_ir(), rand_ir(), 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 4) != 0),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) != 0));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
